acc_x_responder: RTL and testbench
==================================

ACC_X_RESPONDER -- requirements
Module: acc_x_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all state SHALL be clocked on the rising edge of clk_i.
REQ-002 Parameter DataWidth, default 32, SHALL set the operand and result width.
REQ-003 Parameter Depth, default 4, SHALL set the response FIFO depth; it SHALL be a power of two and at least 2.
REQ-004 The ports SHALL be:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- q_instr_data_i  in  32  offloaded instruction
- q_rs_i  in  2xDataWidth  rs1 (index 0) and rs2 (index 1)
- q_rs_valid_i  in  2  operand valid flags
- q_rd_clean_i  in  1  destination register free in the core
- q_valid_i  in  1  request valid
- q_ready_o  out  1  request handshake
- k_accept_o  out  1  instruction accepted; qualified by q_valid_i && q_ready_o
- k_writeback_o  out  2  bit 0 = writeback expected; bit 1 is always 0
- p_data_o  out  DataWidth  result
- p_rd_o  out  5  destination register
- p_error_o  out  1  result error
- p_dualwb_o  out  1  always 0
- p_valid_o  out  1  response valid
- p_ready_i  in  1  response ready

Function
REQ-005 The block SHALL claim an instruction only when opcode[6:0] = 7'b0001011 and funct7 = 0; funct3 selects the operation:
- 000 ADD: rs1+rs2
- 001 SUB: rs1-rs2
- 010 XOR: rs1^rs2
- 011 ACC: acc+rs1, acc updated
- 100 CLR: acc cleared, no writeback
- other funct3: not claimed
REQ-006 For an unclaimed instruction, q_ready_o SHALL be 1 combinationally, with k_accept_o=0 and k_writeback_o=0.
REQ-007 For a claimed instruction, q_ready_o SHALL be 1 only when all of the following hold: every operand the operation uses has its q_rs_valid_i bit set; q_rd_clean_i=1 if writeback is expected; and the FIFO is not full. While q_ready_o=1, k_accept_o SHALL be 1.
REQ-008 The FIFO-not-full condition SHALL be evaluated on the registered count; a pop in the same cycle SHALL NOT admit a request into a full FIFO.
REQ-009 On handshake of a claimed writeback operation, the block SHALL compute the result combinationally, modulo 2^DataWidth, and push {data, rd=instr[11:7], error} into the FIFO.
REQ-010 p_valid_o SHALL first rise in the cycle after the push; it SHALL NOT depend on p_ready_i.
REQ-011 The FIFO SHALL pop on p_valid_o && p_ready_i; its outputs SHALL hold stable while p_valid_o && !p_ready_i.
REQ-012 A push and a pop in the same cycle SHALL leave the count unchanged. The read and write pointers SHALL wrap from Depth-1 to 0.
REQ-013 p_error_o SHALL be 1 only for an ACC operation whose signed addition overflows; the accumulator SHALL still take the wrapped sum.
REQ-014 Responses SHALL be returned in acceptance order.

Reset
REQ-015 While rst_i=1, the FIFO SHALL be empty, pointers and count SHALL be 0, and acc SHALL be 0.
REQ-016 While rst_i=1, p_valid_o=0 and p_data_o, p_rd_o and p_error_o SHALL be 0. q_ready_o, k_accept_o and k_writeback_o remain combinational per REQ-006/007.
REQ-017 Reset asserted mid-operation SHALL discard all queued responses, with no partial response emitted.

Configuration
REQ-018 With macro ACC_X_RESPONDER_ACCU_EN defined, ACC and CLR SHALL be claimed and the acc register SHALL exist.
REQ-019 Without ACC_X_RESPONDER_ACCU_EN, funct3 011/100 SHALL be unclaimed, no acc register SHALL exist, and p_error_o SHALL be constant 0.

Structure
REQ-020 Package acc_x_pkg SHALL hold: the opcode constant, a funct3 enum, the response struct resp_t {data, rd, error}, and a function that returns writeback-expected per funct3.
REQ-021 The response FIFO SHALL be sub-module acc_x_resp_fifo, parameterised by Depth and resp_t.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- ADD, rs1=5, rs2=7, rd=3, both rs valid, rd clean → same-cycle q_ready_o=1, k_accept_o=1, k_writeback_o=01; next cycle p_valid_o=1, p_data_o=12, p_rd_o=3, p_error_o=0.
- Opcode 7'b0110011 → q_ready_o=1 and k_accept_o=0 in the same cycle; no response.
- SUB with q_rs_valid_i=01 for 3 cycles, then 11 → q_ready_o=0 for 3 cycles, then 1; result rs1-rs2 mod 2^32.
- p_ready_i=0, 5 ADDs issued at Depth=4 → 4 accepted, 5th stalled with q_ready_o=0; p_ready_i=1 → 5 responses in order, the 5th accepted only after a pop.
- ACCU_EN: CLR, ACC 0x7FFFFFFF, ACC 1 → responses 0x7FFFFFFF/error 0, then 0x80000000/error 1.
- rst_i pulsed with 3 queued responses → p_valid_o=0 in the next cycle and FIFO empty; acc reads 0 on a subsequent ACC 0.

Source files
------------

// File: rtl/acc_x_pkg.sv
// acc_x_pkg: shared decode constants and response bundle for acc_x_responder.
// The response data field is sized for the widest supported DataWidth.
package acc_x_pkg;

  localparam logic [6:0] AccXOpcode = 7'b0001011;
  localparam int unsigned MaxDataWidth = 64;

  typedef enum logic [2:0] {
    F3_ADD = 3'b000,
    F3_SUB = 3'b001,
    F3_XOR = 3'b010,
    F3_ACC = 3'b011,
    F3_CLR = 3'b100
  } funct3_e;

  typedef struct packed {
    logic [MaxDataWidth-1:0] data;
    logic [4:0]              rd;
    logic                    error;
  } resp_t;

  function automatic logic wb_expected(input logic [2:0] f3);
    case (f3)
      F3_ADD, F3_SUB, F3_XOR, F3_ACC: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/acc_x_resp_fifo.sv
// acc_x_resp_fifo: power-of-two response FIFO, outputs zero while empty.
// Full is taken from the registered count so a same-cycle pop never admits.
module acc_x_resp_fifo #(
  parameter int unsigned Depth = 4,
  parameter type         T     = acc_x_pkg::resp_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     wdata_i,
  input  logic pop_i,
  output T     rdata_o,
  output logic valid_o,
  output logic full_o
);
  localparam int unsigned PW = $clog2(Depth);

  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q;
  logic          do_push, do_pop;
  T              mem_q [Depth];

  assign valid_o = cnt_q != '0;
  assign full_o  = cnt_q == (PW+1)'(Depth);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & valid_o;
  assign rdata_o = valid_o ? mem_q[rptr_q] : '0;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/acc_x_responder.sv
// acc_x_responder: custom-0 offload unit (ADD/SUB/XOR) with ordered responses.
// Define ACC_X_RESPONDER_ACCU_EN to add the accumulator ops ACC and CLR.
module acc_x_responder
  import acc_x_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [31:0]               q_instr_data_i,
  input  logic [1:0][DataWidth-1:0] q_rs_i,
  input  logic [1:0]                q_rs_valid_i,
  input  logic                      q_rd_clean_i,
  input  logic                      q_valid_i,
  output logic                      q_ready_o,
  output logic                      k_accept_o,
  output logic [1:0]                k_writeback_o,
  output logic [DataWidth-1:0]      p_data_o,
  output logic [4:0]                p_rd_o,
  output logic                      p_error_o,
  output logic                      p_dualwb_o,
  output logic                      p_valid_o,
  input  logic                      p_ready_i
);
  logic [2:0]           f3;
  logic                 is_op, is_add, is_sub, is_xor;
  logic                 is_acc, is_clr;
  logic                 claimed, use_rs1, use_rs2, wb;
  logic                 ops_ok, grant, fire, push, full;
  logic [DataWidth-1:0] rs1, rs2, res;
  logic                 res_err;
  resp_t                wdata, rdata;
  logic                 unused_bits;

  assign rs1    = q_rs_i[0];
  assign rs2    = q_rs_i[1];
  assign f3     = q_instr_data_i[14:12];
  assign is_op  = (q_instr_data_i[6:0] == AccXOpcode)
                & (q_instr_data_i[31:25] == 7'd0);
  assign is_add = f3 == F3_ADD;
  assign is_sub = f3 == F3_SUB;
  assign is_xor = f3 == F3_XOR;

`ifdef ACC_X_RESPONDER_ACCU_EN
  logic [DataWidth-1:0] acc_q, acc_sum;
  logic                 acc_ovf;

  assign is_acc  = f3 == F3_ACC;
  assign is_clr  = f3 == F3_CLR;
  assign acc_sum = acc_q + rs1;
  // Signed overflow: equal operand signs, sum sign differs.
  assign acc_ovf = (acc_q[DataWidth-1] == rs1[DataWidth-1])
                 & (acc_sum[DataWidth-1] != acc_q[DataWidth-1]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)               acc_q <= '0;
    else if (fire && is_acc) acc_q <= acc_sum;
    else if (fire && is_clr) acc_q <= '0;
  end

  assign p_error_o = rdata.error;
`else
  assign is_acc    = 1'b0;
  assign is_clr    = 1'b0;
  assign p_error_o = 1'b0;
`endif

  assign claimed = is_op & (is_add | is_sub | is_xor | is_acc | is_clr);
  assign use_rs1 = is_add | is_sub | is_xor | is_acc;
  assign use_rs2 = is_add | is_sub | is_xor;
  assign wb      = wb_expected(f3);
  assign ops_ok  = (~use_rs1 | q_rs_valid_i[0])
                 & (~use_rs2 | q_rs_valid_i[1]);
  assign grant   = ops_ok & (~wb | q_rd_clean_i) & ~full;

  assign q_ready_o     = ~claimed | grant;
  assign k_accept_o    = claimed & grant;
  assign k_writeback_o = {1'b0, claimed & wb};
  assign fire          = q_valid_i & claimed & grant;
  assign push          = fire & wb;

  always_comb begin
    res     = '0;
    res_err = 1'b0;
    unique case (1'b1)
      is_add: res = rs1 + rs2;
      is_sub: res = rs1 - rs2;
      is_xor: res = rs1 ^ rs2;
`ifdef ACC_X_RESPONDER_ACCU_EN
      is_acc: begin
        res     = acc_sum;
        res_err = acc_ovf;
      end
`endif
      default: ;
    endcase
  end

  assign wdata = '{data:  MaxDataWidth'(res),
                   rd:    q_instr_data_i[11:7],
                   error: res_err};

  acc_x_resp_fifo #(
    .Depth (Depth),
    .T     (resp_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (p_ready_i),
    .rdata_o (rdata),
    .valid_o (p_valid_o),
    .full_o  (full)
  );

  assign p_data_o    = rdata.data[DataWidth-1:0];
  assign p_rd_o      = rdata.rd;
  assign p_dualwb_o  = 1'b0;
  assign unused_bits = ^{q_instr_data_i[24:15], rdata};

endmodule

// File: tb/tb_acc_x_responder.sv
// tb_acc_x_responder: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_acc_x_responder;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
`ifdef ACC_X_RESPONDER_ACCU_EN
  localparam bit ACCU = 1'b1;
`else
  localparam bit ACCU = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [31:0]       q_instr_data_i;
  logic [1:0][DW-1:0] q_rs_i;
  logic [1:0]        q_rs_valid_i;
  logic              q_rd_clean_i;
  logic              q_valid_i;
  logic              q_ready_o;
  logic              k_accept_o;
  logic [1:0]        k_writeback_o;
  logic [DW-1:0]     p_data_o;
  logic [4:0]        p_rd_o;
  logic              p_error_o;
  logic              p_dualwb_o;
  logic              p_valid_o;
  logic              p_ready_i;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_acc;
  int          n_total = 0;
  int          n_pass  = 0;

  acc_x_responder #(.DataWidth(DW), .Depth(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .q_instr_data_i (q_instr_data_i),
    .q_rs_i         (q_rs_i),
    .q_rs_valid_i   (q_rs_valid_i),
    .q_rd_clean_i   (q_rd_clean_i),
    .q_valid_i      (q_valid_i),
    .q_ready_o      (q_ready_o),
    .k_accept_o     (k_accept_o),
    .k_writeback_o  (k_writeback_o),
    .p_data_o       (p_data_o),
    .p_rd_o         (p_rd_o),
    .p_error_o      (p_error_o),
    .p_dualwb_o     (p_dualwb_o),
    .p_valid_o      (p_valid_o),
    .p_ready_i      (p_ready_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #400000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  function automatic logic [31:0] mk(input logic [2:0] f3,
                                     input logic [4:0] rd,
                                     input logic [6:0] f7 = 7'd0,
                                     input logic [6:0] opc = 7'b0001011);
    return {f7, 5'd2, 5'd1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_idle();
    q_valid_i      = 1'b0;
    q_instr_data_i = 32'd0;
    q_rs_i         = '0;
    q_rs_valid_i   = 2'b11;
    q_rd_clean_i   = 1'b1;
    p_ready_i      = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    set_idle();
    repeat (2) @(negedge clk_i);
    #1;
    n_total++;
    if (p_valid_o !== 1'b0) $display("FAIL rst_valid: got %b want 0", p_valid_o);
    else n_pass++;
    n_total++;
    if (p_data_o !== 32'd0) $display("FAIL rst_data: got %h want 0", p_data_o);
    else n_pass++;
    n_total++;
    if ({p_rd_o, p_error_o, p_dualwb_o} !== 7'd0)
      $display("FAIL rst_rd_err: got %b want 0", {p_rd_o, p_error_o, p_dualwb_o});
    else n_pass++;
    rst_i = 1'b0;
  endtask

  task automatic test_add();
    @(negedge clk_i);
    q_instr_data_i = mk(3'b000, 5'd3);
    q_rs_i[0] = 32'd5;
    q_rs_i[1] = 32'd7;
    q_valid_i = 1'b1;
    #1;
    n_total++;
    if ({q_ready_o, k_accept_o, k_writeback_o} !== 4'b1101)
      $display("FAIL add_hs: got %b want 1101", {q_ready_o, k_accept_o, k_writeback_o});
    else n_pass++;
    n_total++;
    if (p_valid_o !== 1'b0) $display("FAIL add_early: got %b want 0", p_valid_o);
    else n_pass++;
    @(negedge clk_i);
    q_valid_i = 1'b0;
    #1;
    n_total++;
    if ({p_valid_o, p_data_o, p_rd_o, p_error_o} !== {1'b1, 32'd12, 5'd3, 1'b0})
      $display("FAIL add_resp: got v=%b d=%0d rd=%0d e=%b want 1/12/3/0",
               p_valid_o, p_data_o, p_rd_o, p_error_o);
    else n_pass++;
    @(negedge clk_i);
    #1;
    n_total++;
    if (p_valid_o !== 1'b0) $display("FAIL add_pop: got %b want 0", p_valid_o);
    else n_pass++;
  endtask

  task automatic test_unclaimed();
    @(negedge clk_i);
    q_instr_data_i = mk(3'b000, 5'd4, 7'd0, 7'b0110011);
    q_valid_i = 1'b1;
    #1;
    n_total++;
    if ({q_ready_o, k_accept_o, k_writeback_o} !== 4'b1000)
      $display("FAIL uncl_hs: got %b want 1000", {q_ready_o, k_accept_o, k_writeback_o});
    else n_pass++;
    @(negedge clk_i);
    q_valid_i = 1'b0;
    #1;
    n_total++;
    if (p_valid_o !== 1'b0) $display("FAIL uncl_resp: got %b want 0", p_valid_o);
    else n_pass++;
  endtask

  task automatic test_sub_stall();
    @(negedge clk_i);
    q_instr_data_i = mk(3'b001, 5'd6);
    q_rs_i[0] = 32'd3;
    q_rs_i[1] = 32'd10;
    q_rs_valid_i = 2'b01;
    q_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk_i);
      #1;
      n_total++;
      if (q_ready_o !== 1'b0) $display("FAIL sub_stall%0d: got %b want 0", i, q_ready_o);
      else n_pass++;
    end
    @(negedge clk_i);
    q_rs_valid_i = 2'b11;
    #1;
    n_total++;
    if (q_ready_o !== 1'b1) $display("FAIL sub_go: got %b want 1", q_ready_o);
    else n_pass++;
    @(negedge clk_i);
    q_valid_i = 1'b0;
    #1;
    n_total++;
    if ({p_valid_o, p_data_o, p_rd_o} !== {1'b1, 32'hFFFF_FFF9, 5'd6})
      $display("FAIL sub_resp: got v=%b d=%h rd=%0d want 1/fffffff9/6",
               p_valid_o, p_data_o, p_rd_o);
    else n_pass++;
    @(negedge clk_i);
  endtask

  task automatic test_fifo_full();
    @(negedge clk_i);
    p_ready_i = 1'b0;
    q_valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk_i);
      q_instr_data_i = mk(3'b000, 5'(k + 1));
      q_rs_i[0] = 32'(100 + k);
      q_rs_i[1] = 32'(k);
      #1;
      n_total++;
      if (q_ready_o !== (k < 4))
        $display("FAIL full_fill%0d: got %b want %b", k, q_ready_o, (k < 4));
      else n_pass++;
    end
    @(negedge clk_i);
    p_ready_i = 1'b1;
    #1;
    n_total++;
    if ({q_ready_o, p_data_o, p_rd_o} !== {1'b0, 32'd100, 5'd1})
      $display("FAIL full_popcyc: got r=%b d=%0d rd=%0d want 0/100/1",
               q_ready_o, p_data_o, p_rd_o);
    else n_pass++;
    @(negedge clk_i);
    #1;
    n_total++;
    if ({q_ready_o, p_data_o, p_rd_o} !== {1'b1, 32'd102, 5'd2})
      $display("FAIL full_admit: got r=%b d=%0d rd=%0d want 1/102/2",
               q_ready_o, p_data_o, p_rd_o);
    else n_pass++;
    @(negedge clk_i);
    q_valid_i = 1'b0;
    for (int k = 2; k < 5; k++) begin
      #1;
      n_total++;
      if ({p_valid_o, p_data_o, p_rd_o} !== {1'b1, 32'(100 + 2 * k), 5'(k + 1)})
        $display("FAIL full_order%0d: got v=%b d=%0d rd=%0d want 1/%0d/%0d",
                 k, p_valid_o, p_data_o, p_rd_o, 100 + 2 * k, k + 1);
      else n_pass++;
      @(negedge clk_i);
    end
    #1;
    n_total++;
    if (p_valid_o !== 1'b0) $display("FAIL full_empty: got %b want 0", p_valid_o);
    else n_pass++;
  endtask

`ifdef ACC_X_RESPONDER_ACCU_EN
  task automatic test_accu();
    @(negedge clk_i);
    p_ready_i = 1'b1;
    q_valid_i = 1'b1;
    q_instr_data_i = mk(3'b100, 5'd0);
    #1;
    n_total++;
    if ({q_ready_o, k_accept_o, k_writeback_o} !== 4'b1100)
      $display("FAIL clr_hs: got %b want 1100", {q_ready_o, k_accept_o, k_writeback_o});
    else n_pass++;
    @(negedge clk_i);
    q_instr_data_i = mk(3'b011, 5'd4);
    q_rs_i[0] = 32'h7FFF_FFFF;
    #1;
    n_total++;
    if (p_valid_o !== 1'b0) $display("FAIL clr_noresp: got %b want 0", p_valid_o);
    else n_pass++;
    @(negedge clk_i);
    q_instr_data_i = mk(3'b011, 5'd5);
    q_rs_i[0] = 32'd1;
    #1;
    n_total++;
    if ({p_valid_o, p_data_o, p_rd_o, p_error_o} !== {1'b1, 32'h7FFF_FFFF, 5'd4, 1'b0})
      $display("FAIL acc_first: got v=%b d=%h rd=%0d e=%b want 1/7fffffff/4/0",
               p_valid_o, p_data_o, p_rd_o, p_error_o);
    else n_pass++;
    @(negedge clk_i);
    q_valid_i = 1'b0;
    #1;
    n_total++;
    if ({p_valid_o, p_data_o, p_rd_o, p_error_o} !== {1'b1, 32'h8000_0000, 5'd5, 1'b1})
      $display("FAIL acc_ovf: got v=%b d=%h rd=%0d e=%b want 1/80000000/5/1",
               p_valid_o, p_data_o, p_rd_o, p_error_o);
    else n_pass++;
    @(negedge clk_i);
  endtask
`else
  task automatic test_accu();
    @(negedge clk_i);
    q_valid_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      q_instr_data_i = mk(3'(3 + i), 5'd4);
      #1;
      n_total++;
      if ({q_ready_o, k_accept_o, k_writeback_o} !== 4'b1000)
        $display("FAIL accoff_hs%0d: got %b want 1000", i,
                 {q_ready_o, k_accept_o, k_writeback_o});
      else n_pass++;
      @(negedge clk_i);
    end
    q_valid_i = 1'b0;
    #1;
    n_total++;
    if (p_valid_o !== 1'b0) $display("FAIL accoff_resp: got %b want 0", p_valid_o);
    else n_pass++;
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] want;
    @(negedge clk_i);
    p_ready_i = 1'b0;
    q_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk_i);
      q_instr_data_i = mk(3'b010, 5'(k + 10));
      q_rs_i[0] = $urandom;
      q_rs_i[1] = $urandom;
    end
    @(negedge clk_i);
    q_valid_i = 1'b0;
    #1;
    n_total++;
    if (p_valid_o !== 1'b1) $display("FAIL rmid_queued: got %b want 1", p_valid_o);
    else n_pass++;
    rst_i = 1'b1;
    #1;
    n_total++;
    if ({p_valid_o, p_data_o, p_rd_o} !== 38'd0)
      $display("FAIL rmid_async: got v=%b d=%h rd=%0d want 0", p_valid_o, p_data_o, p_rd_o);
    else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b0;
    p_ready_i = 1'b1;
    #1;
    n_total++;
    if (p_valid_o !== 1'b0) $display("FAIL rmid_empty: got %b want 0", p_valid_o);
    else n_pass++;
    @(negedge clk_i);
    q_valid_i = 1'b1;
    q_rs_i[0] = 32'd0;
    q_rs_i[1] = 32'd9;
    q_instr_data_i = ACCU ? mk(3'b011, 5'd9) : mk(3'b000, 5'd9);
    want = ACCU ? 32'd0 : 32'd9;
    #1;
    n_total++;
    if (q_ready_o !== 1'b1) $display("FAIL rmid_ready: got %b want 1", q_ready_o);
    else n_pass++;
    @(negedge clk_i);
    q_valid_i = 1'b0;
    #1;
    n_total++;
    if ({p_valid_o, p_data_o, p_rd_o} !== {1'b1, want, 5'd9})
      $display("FAIL rmid_after: got v=%b d=%h rd=%0d want 1/%h/9",
               p_valid_o, p_data_o, p_rd_o, want);
    else n_pass++;
    @(negedge clk_i);
  endtask

  task automatic test_random();
    @(negedge clk_i);
    rst_i = 1'b1;
    set_idle();
    @(negedge clk_i);
    rst_i = 1'b0;
    m_acc = 32'd0;
    exp_q.delete();
    for (int c = 0; c < 600; c++) begin
      logic [2:0]  f3;
      logic [6:0]  f7, opc;
      logic [4:0]  rd;
      logic [31:0] a, b, r;
      logic        claimed, use1, use2, wb, rdy, e;
      longint      s;
      @(negedge clk_i);
      f3  = 3'($urandom_range(0, 7));
      f7  = ($urandom_range(0, 9) == 0) ? 7'h20 : 7'h00;
      opc = ($urandom_range(0, 9) == 0) ? 7'b0110011 : 7'b0001011;
      rd  = 5'($urandom);
      a   = pick();
      b   = pick();
      q_instr_data_i = mk(f3, rd, f7, opc);
      q_rs_i[0]      = a;
      q_rs_i[1]      = b;
      q_rs_valid_i   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      q_rd_clean_i   = $urandom_range(0, 4) != 0;
      q_valid_i      = $urandom_range(0, 2) != 0;
      p_ready_i      = $urandom_range(0, 2) != 0;
      #1;
      claimed = (opc == 7'b0001011) && (f7 == 7'd0)
              && (f3 <= 3'd2 || (ACCU && (f3 == 3'd3 || f3 == 3'd4)));
      use1 = f3 != 3'd4;
      use2 = f3 <= 3'd2;
      wb   = f3 != 3'd4;
      rdy  = !claimed || ((!use1 || q_rs_valid_i[0]) && (!use2 || q_rs_valid_i[1])
             && (!wb || q_rd_clean_i) && exp_q.size() < DEPTH);
      n_total++;
      if ({q_ready_o, k_accept_o, k_writeback_o} !== {rdy, claimed && rdy, 1'b0, claimed && wb})
        $display("FAIL rnd_hs c%0d: got %b want %b", c, {q_ready_o, k_accept_o, k_writeback_o},
                 {rdy, claimed && rdy, 1'b0, claimed && wb});
      else n_pass++;
      n_total++;
      if (p_valid_o !== (exp_q.size() != 0))
        $display("FAIL rnd_valid c%0d: got %b want %b", c, p_valid_o, exp_q.size() != 0);
      else n_pass++;
      if (exp_q.size() != 0) begin
        n_total++;
        if ({p_data_o, p_rd_o, p_error_o} !== {exp_q[0].data, exp_q[0].rd, exp_q[0].err})
          $display("FAIL rnd_resp c%0d: got d=%h rd=%0d e=%b want d=%h rd=%0d e=%b", c,
                   p_data_o, p_rd_o, p_error_o, exp_q[0].data, exp_q[0].rd, exp_q[0].err);
        else n_pass++;
        if (p_ready_i) void'(exp_q.pop_front());
      end
      if (q_valid_i && claimed && rdy) begin
        r = 32'd0;
        e = 1'b0;
        case (f3)
          3'd0: r = a + b;
          3'd1: r = a - b;
          3'd2: r = a ^ b;
          3'd3: begin
            s = longint'($signed(m_acc)) + longint'($signed(a));
            e = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            r = m_acc + a;
            m_acc = r;
          end
          default: m_acc = 32'd0;
        endcase
        if (wb) exp_q.push_back('{data: r, rd: rd, err: e});
      end
    end
    @(negedge clk_i);
    q_valid_i = 1'b0;
    p_ready_i = 1'b1;
    for (int c = 0; c < DEPTH + 1; c++) begin
      #1;
      n_total++;
      if (p_valid_o !== (exp_q.size() != 0))
        $display("FAIL drain_valid c%0d: got %b want %b", c, p_valid_o, exp_q.size() != 0);
      else n_pass++;
      if (exp_q.size() != 0) begin
        n_total++;
        if ({p_data_o, p_rd_o, p_error_o} !== {exp_q[0].data, exp_q[0].rd, exp_q[0].err})
          $display("FAIL drain_resp c%0d: got d=%h rd=%0d want d=%h rd=%0d", c,
                   p_data_o, p_rd_o, exp_q[0].data, exp_q[0].rd);
        else n_pass++;
        void'(exp_q.pop_front());
      end
      @(negedge clk_i);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    set_idle();
    test_reset();
    test_add();
    test_unclaimed();
    test_sub_stall();
    test_fifo_full();
    test_accu();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
